// File: rtl/next_queue_scroller.sv
// next_queue_scroller: renders the "next pieces" panel beside the playfield.
//
// Draws NUM_PIECES upcoming tetrominos (orientation 0) in vertically stacked
// slots. The queue is latched only on frame_start, so the panel never tears
// mid-frame. Each queue advance restarts an upward slide of one slot pitch,
// which is removed SCROLL_STEP pixels per frame.
//
// Piece encoding (3 bits): 0 BLANK, 1 I, 2 O, 3 T, 4 J, 5 L, 6 S, 7 Z.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   VGA_row/VGA_col pixel currently presented by the VGA timing
//   frame_start     one-cycle pulse at the start of vertical blank
//   queue_advance   one-cycle pulse when the head of the queue is consumed
//   pieces_queue    live queue, entry 0 is the next piece
//   output_color    registered RGB for the pixel presented one cycle earlier
//   active          registered in-panel flag, same stage as output_color
//   scroll_busy     high while a slide is in progress
module next_queue_scroller #(
    parameter int unsigned NUM_PIECES  = 5,
    parameter int unsigned HSTART      = 400,
    parameter int unsigned VSTART      = 40,
    parameter int unsigned TILE_W      = 20,
    parameter int unsigned TILE_H      = 20,
    parameter int unsigned SLOT_ROWS   = 3,
    parameter int unsigned PANEL_COLS  = 6,
    parameter int unsigned SCROLL_STEP = 4,
    parameter logic [23:0] TILE_BLANK_COLOR  = 24'h101010,
    parameter logic [23:0] TETROMINO_I_COLOR = 24'h00FFFF,
    parameter logic [23:0] TETROMINO_O_COLOR = 24'hFFFF00,
    parameter logic [23:0] TETROMINO_T_COLOR = 24'h800080,
    parameter logic [23:0] TETROMINO_J_COLOR = 24'h0000FF,
    parameter logic [23:0] TETROMINO_L_COLOR = 24'hFFA500,
    parameter logic [23:0] TETROMINO_S_COLOR = 24'h00FF00,
    parameter logic [23:0] TETROMINO_Z_COLOR = 24'hFF0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [9:0]                   VGA_row,
    input  logic [9:0]                   VGA_col,
    input  logic                         frame_start,
    input  logic                         queue_advance,
    input  logic [NUM_PIECES-1:0][2:0]   pieces_queue,
    output logic [23:0]                  output_color,
    output logic                         active,
    output logic                         scroll_busy
);

    localparam int unsigned PITCH_PX  = SLOT_ROWS * TILE_H;
    localparam int unsigned TILE_ROWS = NUM_PIECES * SLOT_ROWS + 1;
    localparam logic [10:0] ROW_LO    = 11'(VSTART);
    localparam logic [10:0] ROW_HI    = 11'(VSTART + TILE_ROWS * TILE_H);
    localparam logic [10:0] COL_LO    = 11'(HSTART);
    localparam logic [10:0] COL_HI    = 11'(HSTART + PANEL_COLS * TILE_W);

    localparam logic [2:0] T_BLANK = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_O     = 3'd2;
    localparam logic [2:0] T_T     = 3'd3;
    localparam logic [2:0] T_J     = 3'd4;
    localparam logic [2:0] T_L     = 3'd5;
    localparam logic [2:0] T_S     = 3'd6;
    localparam logic [2:0] T_Z     = 3'd7;

    // Cell (r,c) of the local 2x4 box covered by piece t in orientation 0.
    function automatic logic shape_hit(input logic [2:0] t, input logic r,
                                       input logic [1:0] c);
        logic mid;
        mid = (c == 2'd1) || (c == 2'd2);
        case (t)
            T_I:     shape_hit = !r;
            T_O:     shape_hit = mid;
            T_T:     shape_hit = r ? (c != 2'd3) : (c == 2'd1);
            T_J:     shape_hit = r ? (c != 2'd3) : (c == 2'd0);
            T_L:     shape_hit = r ? (c != 2'd3) : (c == 2'd2);
            T_S:     shape_hit = r ? (c <= 2'd1) : mid;
            T_Z:     shape_hit = r ? mid : (c <= 2'd1);
            default: shape_hit = 1'b0;
        endcase
    endfunction

    function automatic logic [23:0] type_color(input logic [2:0] t);
        case (t)
            T_I:     type_color = TETROMINO_I_COLOR;
            T_O:     type_color = TETROMINO_O_COLOR;
            T_T:     type_color = TETROMINO_T_COLOR;
            T_J:     type_color = TETROMINO_J_COLOR;
            T_L:     type_color = TETROMINO_L_COLOR;
            T_S:     type_color = TETROMINO_S_COLOR;
            T_Z:     type_color = TETROMINO_Z_COLOR;
            default: type_color = TILE_BLANK_COLOR;
        endcase
    endfunction

    logic [NUM_PIECES-1:0][2:0] disp_buf;
    logic [9:0]                 scroll_off;
    logic                       adv_pending;

    // Buffer and scroll offset move only on frame boundaries; an advance in
    // the same cycle as frame_start counts for this frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_buf    <= '0;
            scroll_off  <= '0;
            adv_pending <= 1'b0;
        end else if (frame_start) begin
            disp_buf    <= pieces_queue;
            adv_pending <= 1'b0;
            if (adv_pending || queue_advance) begin
                scroll_off <= 10'(PITCH_PX);
            end else if (scroll_off > 10'(SCROLL_STEP)) begin
                scroll_off <= scroll_off - 10'(SCROLL_STEP);
            end else begin
                scroll_off <= '0;
            end
        end else if (queue_advance) begin
            adv_pending <= 1'b1;
        end
    end

    assign scroll_busy = (scroll_off != '0);

    logic               in_region;
    logic signed [11:0] rel_row;
    logic [9:0]         col_off;
    logic [7:0]         tile_r;
    logic [7:0]         tile_c;
    logic               in_slot;
    logic               local_r;
    logic [1:0]         local_c;
    logic [2:0]         cur_type;
    logic [23:0]        pix_color;

    always_comb begin
        in_region = ({1'b0, VGA_row} >= ROW_LO) && ({1'b0, VGA_row} < ROW_HI) &&
                    ({1'b0, VGA_col} >= COL_LO) && ({1'b0, VGA_col} < COL_HI);
        rel_row   = $signed({2'b00, VGA_row}) - $signed(12'(VSTART)) -
                    $signed({2'b00, scroll_off});
        col_off   = VGA_col - 10'(HSTART);

        // Tile index by comparing against tile boundaries instead of dividing.
        tile_r = '0;
        for (int unsigned i = 1; i < TILE_ROWS; i++) begin
            if (rel_row >= $signed(12'(i * TILE_H))) tile_r = 8'(i);
        end
        tile_c = '0;
        for (int unsigned i = 1; i < PANEL_COLS; i++) begin
            if (col_off >= 10'(i * TILE_W)) tile_c = 8'(i);
        end

        // Slot k owns tile rows SLOT_ROWS*k+1 and +2; anything else is gap.
        in_slot  = 1'b0;
        local_r  = 1'b0;
        cur_type = T_BLANK;
        for (int unsigned k = 0; k < NUM_PIECES; k++) begin
            if (tile_r == 8'(k * SLOT_ROWS + 1)) begin
                in_slot  = 1'b1;
                local_r  = 1'b0;
                cur_type = disp_buf[k];
            end
            if (tile_r == 8'(k * SLOT_ROWS + 2)) begin
                in_slot  = 1'b1;
                local_r  = 1'b1;
                cur_type = disp_buf[k];
            end
        end
        local_c = 2'(tile_c - 8'd1);

        pix_color = TILE_BLANK_COLOR;
        if (in_region && !rel_row[11] && in_slot && (tile_c >= 8'd1) && (tile_c <= 8'd4) &&
            shape_hit(cur_type, local_r, local_c)) begin
            pix_color = type_color(cur_type);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_color <= 24'h000000;
            active       <= 1'b0;
        end else begin
            output_color <= pix_color;
            active       <= in_region;
        end
    end

endmodule
